// File: rtl/vdb_output_monitor.sv
// vdb_output_monitor: per-channel change detector feeding a timestamped,
// round-robin arbitrated, first-word fall-through event FIFO.
module vdb_output_monitor #(
   parameter int CHANNELS = 16,
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 16,
   parameter int TS_WIDTH = 32,
   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   localparam int AW = $clog2(DEPTH),
   localparam int FW = AW + 1
) (
   input  logic                      CLK_50,
   input  logic                      RST_N,
   input  logic [CHANNELS*WIDTH-1:0] IN_DATA,
   input  logic [CHANNELS-1:0]       IN_MASK,
   output logic                      EVT_VALID,
   input  logic                      EVT_READY,
   output logic [CW-1:0]             EVT_CHANNEL,
   output logic [WIDTH-1:0]          EVT_VALUE,
   output logic [TS_WIDTH-1:0]       EVT_TIME,
   output logic [FW-1:0]             FILL,
   output logic                      OVERFLOW,
   input  logic                      OVF_CLR
);

   localparam int EW = CW + WIDTH + TS_WIDTH;
   localparam logic [FW-1:0] FULL_LVL = FW'(DEPTH);
   localparam logic [CW-1:0] LAST_CH  = CW'(CHANNELS - 1);

   logic [WIDTH-1:0]    sample [CHANNELS];
   logic [WIDTH-1:0]    shadow [CHANNELS];
   logic [TS_WIDTH-1:0] ts;
   logic [CW-1:0]       ptr;
   logic [EW-1:0]       mem [DEPTH];
   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   logic [FW-1:0]       fill;
   logic                ovf;

   logic [CHANNELS-1:0] pending;
   logic                hi_hit;
   logic                lo_hit;
   logic [CW-1:0]       hi_idx;
   logic [CW-1:0]       lo_idx;
   logic [WIDTH-1:0]    hi_val;
   logic [WIDTH-1:0]    lo_val;
   logic                grant;
   logic [CW-1:0]       gnt;
   logic [WIDTH-1:0]    gnt_val;
   logic [CW-1:0]       ptr_nxt;
   logic                full;
   logic                push;
   logic                pop;
   logic                blocked;
   logic [EW-1:0]       head;

   // Descending scan so the last hit is the lowest index; the hi set
   // only admits channels at or above the pointer, lo is the wrap case.
   always_comb begin
      pending = '0;
      hi_hit  = 1'b0;
      lo_hit  = 1'b0;
      hi_idx  = '0;
      lo_idx  = '0;
      hi_val  = '0;
      lo_val  = '0;
      for (int c = CHANNELS - 1; c >= 0; c--) begin
         pending[c] = IN_MASK[c] && (sample[c] != shadow[c]);
         if (pending[c]) begin
            lo_hit = 1'b1;
            lo_idx = CW'(c);
            lo_val = sample[c];
            if (CW'(c) >= ptr) begin
               hi_hit = 1'b1;
               hi_idx = CW'(c);
               hi_val = sample[c];
            end
         end
      end
   end

   assign grant   = hi_hit | lo_hit;
   assign gnt     = hi_hit ? hi_idx : lo_idx;
   assign gnt_val = hi_hit ? hi_val : lo_val;
   assign ptr_nxt = (gnt == LAST_CH) ? '0 : gnt + CW'(1);

   assign full    = (fill == FULL_LVL);
   assign push    = grant && !full;
   assign blocked = grant && full;
   assign pop     = (fill != '0) && EVT_READY;

   always_ff @(posedge CLK_50 or negedge RST_N) begin
      if (!RST_N) begin
         ts  <= '0;
         ptr <= '0;
         for (int c = 0; c < CHANNELS; c++) begin
            sample[c] <= '0;
            shadow[c] <= '0;
         end
      end else begin
         ts <= ts + TS_WIDTH'(1);
         for (int c = 0; c < CHANNELS; c++) begin
            sample[c] <= IN_DATA[c*WIDTH +: WIDTH];
            if (push && gnt == CW'(c))
               shadow[c] <= gnt_val;
         end
         if (push)
            ptr <= ptr_nxt;
      end
   end

   always_ff @(posedge CLK_50) begin
      if (push)
         mem[wr_ptr] <= {gnt, gnt_val, ts};
   end

   // Fill is the full/empty authority; pointers wrap naturally.
   always_ff @(posedge CLK_50 or negedge RST_N) begin
      if (!RST_N) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fill   <= '0;
         ovf    <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   fill <= fill + FW'(1);
            2'b01:   fill <= fill - FW'(1);
            default: fill <= fill;
         endcase
         if (blocked)
            ovf <= 1'b1;
         else if (OVF_CLR)
            ovf <= 1'b0;
      end
   end

   assign head      = mem[rd_ptr];
   assign EVT_VALID = (fill != '0);
   assign {EVT_CHANNEL, EVT_VALUE, EVT_TIME} = EVT_VALID ? head : '0;
   assign FILL      = fill;
   assign OVERFLOW  = ovf;

endmodule

// File: tb/tb_vdb_output_monitor.sv
// Bench for vdb_output_monitor: directed scenarios plus random traffic,
// an event-level reference model and a decoupled scoreboard monitor.
module tb_vdb_output_monitor;

   localparam int CH  = 16;
   localparam int W   = 8;
   localparam int D   = 16;
   localparam int TSW = 4;

   logic          CLK_50 = 1'b0;
   logic          RST_N;
   logic [CH*W-1:0] IN_DATA;
   logic [CH-1:0] IN_MASK;
   logic          EVT_VALID;
   logic          EVT_READY;
   logic [3:0]    EVT_CHANNEL;
   logic [W-1:0]  EVT_VALUE;
   logic [TSW-1:0] EVT_TIME;
   logic [4:0]    FILL;
   logic          OVERFLOW;
   logic          OVF_CLR;

   typedef struct {
      int ch;
      int val;
      int tm;
   } evt_t;

   evt_t sb_q[$];
   int   pop_ch[$];
   int   pop_tm[$];
   int   checks = 0;
   int   failures = 0;

   int   m_sample [CH];
   int   m_shadow [CH];
   int   last_val [CH];
   int   m_ptr;
   int   m_ts;
   int   m_fill;
   int   m_g;
   int   m_c;
   bit   m_pop;
   bit   m_ovf;
   evt_t m_e;

   vdb_output_monitor #(
      .CHANNELS(CH),
      .WIDTH(W),
      .DEPTH(D),
      .TS_WIDTH(TSW)
   ) dut (
      .CLK_50(CLK_50),
      .RST_N(RST_N),
      .IN_DATA(IN_DATA),
      .IN_MASK(IN_MASK),
      .EVT_VALID(EVT_VALID),
      .EVT_READY(EVT_READY),
      .EVT_CHANNEL(EVT_CHANNEL),
      .EVT_VALUE(EVT_VALUE),
      .EVT_TIME(EVT_TIME),
      .FILL(FILL),
      .OVERFLOW(OVERFLOW),
      .OVF_CLR(OVF_CLR)
   );

   always #10 CLK_50 = ~CLK_50;

   task automatic chk(input string name, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   // Reference model: which channel differs from its last report,
   // round-robin choice, queue capacity, and a cycle counter.
   always @(posedge CLK_50 or negedge RST_N) begin
      if (!RST_N) begin
         for (int c = 0; c < CH; c++) begin
            m_sample[c] = 0;
            m_shadow[c] = 0;
         end
         m_ptr  = 0;
         m_ts   = 0;
         m_fill = 0;
         m_ovf  = 1'b0;
         sb_q.delete();
      end else begin
         m_pop = EVT_READY && (m_fill > 0);
         m_g = -1;
         for (int k = 0; k < CH; k++) begin
            m_c = (m_ptr + k) % CH;
            if (m_g < 0 && IN_MASK[m_c] && m_sample[m_c] != m_shadow[m_c])
               m_g = m_c;
         end
         if (m_g >= 0 && m_fill == D)
            m_ovf = 1'b1;
         else if (OVF_CLR)
            m_ovf = 1'b0;
         if (m_g >= 0 && m_fill < D) begin
            m_e.ch  = m_g;
            m_e.val = m_sample[m_g];
            m_e.tm  = m_ts;
            sb_q.push_back(m_e);
            m_shadow[m_g] = m_sample[m_g];
            m_ptr = (m_g + 1) % CH;
            m_fill++;
         end
         if (m_pop)
            m_fill--;
         for (int c = 0; c < CH; c++)
            m_sample[c] = int'(IN_DATA[c*W +: W]);
         m_ts = (m_ts + 1) % (1 << TSW);
      end
   end

   always @(negedge CLK_50) begin
      if (RST_N) begin
         chk("fill", FILL, m_fill);
         chk("overflow", OVERFLOW, m_ovf);
         chk("valid", EVT_VALID, m_fill != 0);
         if (EVT_VALID) begin
            if (sb_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL spurious_event got=ch%0d exp=none",
                        EVT_CHANNEL);
            end else begin
               chk("evt_channel", EVT_CHANNEL, sb_q[0].ch);
               chk("evt_value", EVT_VALUE, sb_q[0].val);
               chk("evt_time", EVT_TIME, sb_q[0].tm);
               if (EVT_READY) begin
                  last_val[sb_q[0].ch] = int'(EVT_VALUE);
                  pop_ch.push_back(int'(EVT_CHANNEL));
                  pop_tm.push_back(int'(EVT_TIME));
                  void'(sb_q.pop_front());
               end
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge CLK_50);
         #2;
      end
   endtask

   task automatic set_ch(input int c, input int v);
      IN_DATA[c*W +: W] = W'(v);
   endtask

   task automatic do_reset();
      RST_N   = 1'b0;
      IN_DATA = '0;
      IN_MASK = '1;
      tick(2);
      RST_N = 1'b1;
   endtask

   initial begin
      int k;
      RST_N     = 1'b0;
      IN_DATA   = '0;
      IN_MASK   = '1;
      EVT_READY = 1'b0;
      OVF_CLR   = 1'b0;
      for (int c = 0; c < CH; c++)
         last_val[c] = -1;
      tick(2);
      chk("rst_fill", FILL, 0);
      chk("rst_valid", EVT_VALID, 0);
      chk("rst_chan", EVT_CHANNEL, 0);
      chk("rst_value", EVT_VALUE, 0);
      chk("rst_time", EVT_TIME, 0);
      chk("rst_ovf", OVERFLOW, 0);

      // single change: sampled at edge 10, pushed at edge 11
      RST_N = 1'b1;
      tick(10);
      chk("idle_fill", FILL, 0);
      set_ch(3, 8'h5A);
      tick(2);
      chk("t1_valid", EVT_VALID, 1);
      chk("t1_chan", EVT_CHANNEL, 3);
      chk("t1_value", EVT_VALUE, 8'h5A);
      chk("t1_time", EVT_TIME, 11);
      chk("t1_fill", FILL, 1);

      // three simultaneous changes from a fresh pointer
      EVT_READY = 1'b1;
      do_reset();
      pop_ch.delete();
      pop_tm.delete();
      set_ch(0, 8'h11);
      set_ch(5, 8'h55);
      set_ch(15, 8'hF0);
      tick(8);
      chk("t2_count", pop_ch.size(), 3);
      if (pop_ch.size() == 3) begin
         chk("t2_ord0", pop_ch[0], 0);
         chk("t2_ord1", pop_ch[1], 5);
         chk("t2_ord2", pop_ch[2], 15);
         chk("t2_ts1", (pop_tm[1] - pop_tm[0] + 16) % 16, 1);
         chk("t2_ts2", (pop_tm[2] - pop_tm[1] + 16) % 16, 1);
      end
      chk("t2_fill", FILL, 0);

      // overflow with one busy channel
      EVT_READY = 1'b0;
      for (int v = 1; v <= 40; v++) begin
         set_ch(1, v);
         tick(1);
      end
      chk("t3_fill", FILL, 16);
      chk("t3_ovf", OVERFLOW, 1);
      OVF_CLR = 1'b1;
      tick(1);
      OVF_CLR = 1'b0;
      chk("t3_ovf_prio", OVERFLOW, 1);
      EVT_READY = 1'b1;
      tick(25);
      chk("t3_drained", FILL, 0);
      chk("t3_last", last_val[1], 40);
      OVF_CLR = 1'b1;
      tick(1);
      OVF_CLR = 1'b0;
      chk("t3_ovf_clr", OVERFLOW, 0);

      // masked channel reports once on unmask
      EVT_READY  = 1'b0;
      IN_MASK[7] = 1'b0;
      set_ch(7, 1);
      tick(1);
      set_ch(7, 2);
      tick(1);
      set_ch(7, 3);
      tick(3);
      chk("t4_masked", FILL, 0);
      IN_MASK[7] = 1'b1;
      tick(3);
      chk("t4_fill", FILL, 1);
      chk("t4_chan", EVT_CHANNEL, 7);
      chk("t4_value", EVT_VALUE, 3);
      EVT_READY = 1'b1;
      tick(2);

      // stall with 9 queued, then asynchronous flush
      EVT_READY = 1'b0;
      set_ch(2, 8'h21);
      set_ch(4, 8'h41);
      set_ch(6, 8'h61);
      set_ch(8, 8'h81);
      set_ch(9, 8'h91);
      set_ch(10, 8'hA1);
      set_ch(11, 8'hB1);
      set_ch(12, 8'hC1);
      set_ch(13, 8'hD1);
      tick(12);
      chk("t5_fill", FILL, 9);
      tick(5);
      RST_N = 1'b0;
      #1;
      chk("t5_rst_fill", FILL, 0);
      chk("t5_rst_valid", EVT_VALID, 0);
      chk("t5_rst_ovf", OVERFLOW, 0);
      IN_DATA = '0;
      tick(1);

      // timestamp wrap: pushed at edge 17 -> 17 mod 16
      RST_N = 1'b1;
      tick(16);
      set_ch(2, 8'h33);
      tick(2);
      chk("t6_valid", EVT_VALID, 1);
      chk("t6_chan", EVT_CHANNEL, 2);
      chk("t6_time", EVT_TIME, 1);

      // random traffic
      EVT_READY = 1'b1;
      tick(2);
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(99) < 30)
            set_ch($urandom_range(CH - 1), $urandom_range(3));
         if ($urandom_range(99) < 10)
            set_ch($urandom_range(CH - 1), $urandom_range(255));
         if ($urandom_range(99) < 3) begin
            k = $urandom_range(CH - 1);
            IN_MASK[k] = ~IN_MASK[k];
         end
         EVT_READY = ($urandom_range(99) < 50);
         OVF_CLR   = ($urandom_range(99) < 5);
         if ($urandom_range(999) < 3) begin
            RST_N = 1'b0;
            tick(1);
            RST_N = 1'b1;
         end
         tick(1);
      end

      IN_MASK   = '1;
      OVF_CLR   = 1'b0;
      EVT_READY = 1'b1;
      tick(60);
      chk("end_fill", FILL, 0);
      chk("end_sb_empty", sb_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
